// File: rtl/onehot_sequencer.sv
// Walks one active select bit across the first L of WIDTH lines, P passes,
// ascending or descending, with stall (en low) and immediate abort.
module onehot_sequencer #(
  parameter int WIDTH = 280,
  parameter int IDXW  = 9,
  parameter int PW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDXW-1:0]  len,
  input  logic [PW-1:0]    passes,
  input  logic             dir,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] sel,
  output logic [IDXW-1:0]  idx,
  output logic             wrap,
  output logic             done,
  output logic             busy,
  output logic             dbg_state
);

  // Handshake: start is a level that is accepted on any rising edge where busy
  // is low; there is no backpressure, and len/passes/dir are captured on that
  // same edge. done/wrap are single-cycle pulses with no acknowledge.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nx;
  logic [IDXW-1:0] pos, pos_nx;
  logic [IDXW-1:0] len_q, len_nx;
  logic [PW-1:0]   rem_q, rem_nx;
  logic            dir_q, dir_nx;
  logic            wrap_nx, done_nx;
  logic [IDXW-1:0] eff_len;
  logic            at_last;

  // Zero or oversize lengths mean "use every line".
  assign eff_len = ((len == '0) || (len > IDXW'(WIDTH))) ? IDXW'(WIDTH) : len;
  assign at_last = dir_q ? (pos == '0) : (pos == (len_q - IDXW'(1)));

  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    len_nx   = len_q;
    rem_nx   = rem_q;
    dir_nx   = dir_q;
    wrap_nx  = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          len_nx   = eff_len;
          rem_nx   = (passes == '0) ? PW'(1) : passes;
          dir_nx   = dir;
          pos_nx   = dir ? (eff_len - IDXW'(1)) : '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
          pos_nx   = '0;
        end else if (en) begin
          if (!at_last) begin
            pos_nx = dir_q ? (pos - IDXW'(1)) : (pos + IDXW'(1));
          end else if (rem_q > PW'(1)) begin
            pos_nx  = dir_q ? (len_q - IDXW'(1)) : '0;
            rem_nx  = rem_q - PW'(1);
            wrap_nx = 1'b1;
          end else begin
            state_nx = IDLE;
            pos_nx   = '0;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pos   <= '0;
      len_q <= '0;
      rem_q <= '0;
      dir_q <= 1'b0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      pos   <= pos_nx;
      len_q <= len_nx;
      rem_q <= rem_nx;
      dir_q <= dir_nx;
      wrap  <= wrap_nx;
      done  <= done_nx;
    end
  end

  assign busy      = (state == RUN);
  assign dbg_state = state;
  assign idx       = pos;

  always_comb begin
    sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sel[i] = busy && (pos == IDXW'(i));
    end
  end

endmodule

// File: tb/tb_onehot_sequencer.sv
// Directed bench for onehot_sequencer at WIDTH=8: stepping, passes, clamping,
// stalls, abort, back-to-back starts and asynchronous reset.
module tb_onehot_sequencer;

  localparam int WIDTH = 8;
  localparam int IDXW  = 4;
  localparam int PW    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [IDXW-1:0]  len = '0;
  logic [PW-1:0]    passes = '0;
  logic             dir = 1'b0;
  logic             en = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] sel;
  logic [IDXW-1:0]  idx;
  logic             wrap, done, busy, dbg_state;

  int checks = 0;
  int errors = 0;

  onehot_sequencer #(.WIDTH(WIDTH), .IDXW(IDXW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .passes(passes), .dir(dir),
    .en(en), .abort(abort), .sel(sel), .idx(idx), .wrap(wrap), .done(done),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [IDXW-1:0] l, input logic [PW-1:0] p,
                        input logic d, input logic e);
    len = l; passes = p; dir = d; en = e; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    checks++; if ({sel, idx, wrap, done, busy, dbg_state} !== '0) begin errors++;
      $display("FAIL reset_outputs: sel=%h idx=%0d wrap=%b done=%b busy=%b st=%b, all required 0", sel, idx, wrap, done, busy, dbg_state); end
    step(); step();
    rst = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || sel !== 8'h00) begin errors++;
      $display("FAIL reset_idle_after_release: busy=%b sel=%h, required 0/00", busy, sel); end
  endtask

  task automatic test_ascending();
    logic [WIDTH-1:0] one = 8'h01;
    int wraps = 0;
    launch(4'd8, 8'd1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++; if (sel !== (one << i) || idx !== IDXW'(i) || busy !== 1'b1 || done !== 1'b0) begin errors++;
        $display("FAIL asc_step%0d: sel=%h idx=%0d busy=%b done=%b, required sel=%h idx=%0d busy=1 done=0", i, sel, idx, busy, done, one << i, i); end
      if (wrap) wraps++;
      step();
    end
    checks++; if (done !== 1'b1 || sel !== 8'h00 || busy !== 1'b0 || idx !== '0) begin errors++;
      $display("FAIL asc_done: done=%b sel=%h busy=%b idx=%0d, required 1/00/0/0", done, sel, busy, idx); end
    checks++; if (wraps !== 0 || wrap !== 1'b0) begin errors++;
      $display("FAIL asc_no_wrap: wraps=%0d, required 0", wraps); end
    // back-to-back: start accepted in the done cycle
    launch(4'd8, 8'd1, 1'b1, 1'b0);
    checks++; if (done !== 1'b0 || busy !== 1'b1 || sel !== 8'h80 || idx !== 4'd7) begin errors++;
      $display("FAIL b2b_start: done=%b busy=%b sel=%h idx=%0d, required 0/1/80/7", done, busy, sel, idx); end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_descending_wrap();
    logic [WIDTH-1:0] one = 8'h01;
    int wraps = 0;
    int busy_cycles = 0;
    int k;
    launch(4'd3, 8'd2, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      k = 2 - (i % 3);
      checks++; if (sel !== (one << k) || idx !== IDXW'(k) || wrap !== (i == 3)) begin errors++;
        $display("FAIL desc_step%0d: sel=%h idx=%0d wrap=%b, required sel=%h idx=%0d wrap=%b", i, sel, idx, wrap, one << k, k, i == 3); end
      if (wrap) wraps++;
      if (busy) busy_cycles++;
      step();
    end
    checks++; if (done !== 1'b1 || sel !== 8'h00 || wrap !== 1'b0) begin errors++;
      $display("FAIL desc_done: done=%b sel=%h wrap=%b, required 1/00/0", done, sel, wrap); end
    checks++; if (wraps !== 1 || busy_cycles !== 6) begin errors++;
      $display("FAIL desc_counts: wraps=%0d busy_cycles=%0d, required 1/6", wraps, busy_cycles); end
    step();
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL desc_done_pulse: done=%b, required 0", done); end
  endtask

  task automatic test_len_clamp();
    logic [IDXW-1:0] lens [2] = '{4'd0, 4'd12};
    int n;
    int max_idx;
    for (int t = 0; t < 2; t++) begin
      launch(lens[t], 8'd0, 1'b0, 1'b1);
      n = 0; max_idx = 0;
      while (!done && n < 20) begin
        if (int'(idx) > max_idx) max_idx = int'(idx);
        step();
        n++;
      end
      checks++; if (n !== 8 || max_idx !== 7) begin errors++;
        $display("FAIL clamp_len%0d: en_cycles=%0d max_idx=%0d, required 8/7", lens[t], n, max_idx); end
      step();
    end
  endtask

  task automatic test_en_toggle();
    logic       ens  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exps [6] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd0};
    launch(4'd4, 8'd1, 1'b0, 1'b0);
    checks++; if (idx !== 4'd0 || sel !== 8'h01) begin errors++;
      $display("FAIL stall_first: idx=%0d sel=%h, required 0/01", idx, sel); end
    for (int i = 0; i < 6; i++) begin
      en = ens[i];
      step();
      checks++; if (idx !== exps[i] || done !== (i == 5) || busy !== (i != 5)) begin errors++;
        $display("FAIL stall_step%0d: idx=%0d done=%b busy=%b, required idx=%0d done=%b busy=%b", i, idx, done, busy, exps[i], i == 5, i != 5); end
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_abort();
    launch(4'd8, 8'd1, 1'b0, 1'b1);
    step();
    len = 4'd3; dir = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (idx !== 4'd2 || sel !== 8'h04) begin errors++;
      $display("FAIL start_ignored: idx=%0d sel=%h, required 2/04", idx, sel); end
    abort = 1'b1; en = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (sel !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0 || idx !== '0) begin errors++;
      $display("FAIL abort: sel=%h busy=%b done=%b wrap=%b idx=%0d, required all 0", sel, busy, done, wrap, idx); end
    launch(4'd2, 8'd1, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || sel !== 8'h01 || done !== 1'b0) begin errors++;
      $display("FAIL restart_after_abort: busy=%b sel=%h done=%b, required 1/01/0", busy, sel, done); end
    en = 1'b1;
    step(); step();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL restart_done: done=%b busy=%b, required 1/0", done, busy); end
    en = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    launch(4'd8, 8'd1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step();
    checks++; if (idx !== 4'd5 || sel !== 8'h20) begin errors++;
      $display("FAIL areset_pre: idx=%0d sel=%h, required 5/20", idx, sel); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({sel, idx, wrap, done, busy} !== '0) begin errors++;
      $display("FAIL areset_immediate: sel=%h idx=%0d wrap=%b done=%b busy=%b, required all 0", sel, idx, wrap, done, busy); end
    step();
    rst = 1'b1;
    step(); step();
    checks++; if (busy !== 1'b0 || sel !== 8'h00 || idx !== '0) begin errors++;
      $display("FAIL areset_idle: busy=%b sel=%h idx=%0d, required 0/00/0", busy, sel, idx); end
    launch(4'd8, 8'd1, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || sel !== 8'h01) begin errors++;
      $display("FAIL areset_restart: busy=%b sel=%h, required 1/01", busy, sel); end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending_wrap();
    test_len_clamp();
    test_en_toggle();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
